pll_dyn_ctrl: RTL and testbench
===============================

Name: pll_dyn_ctrl

Overview:
- Dynamic-reconfiguration controller for the vendor rPLL in the capture front end.
- Drives the PLL's IDSEL/FBDSEL/ODSEL/PSDA/DUTYDA dynamic-select inputs and its RESET/RESET_P pins.
- Qualifies the asynchronous lock signal and recovers automatically from lock loss.
- Replaces the fixed-divider PLL setup; the capture clock and the phase used against the DSI bridge data can be retuned at runtime without a rebuild.

Parameters:
- DEF_IDSEL, 6'd63, power-up IDSEL in vendor dynamic encoding; with the other defaults gives the 50→150 MHz setting.
- DEF_FBDSEL, 6'd61, power-up FBDSEL (encoded).
- DEF_ODSEL, 6'd62, power-up ODSEL (encoded).
- DEF_PSDA, 4'd4, power-up phase step.
- DEF_DUTYDA, 4'd8, power-up duty step.
- RST_CYCLES, 16, clkin cycles pll_reset / pll_reset_p are held high.
- SETTLE_CYCLES, 1024, consecutive synced-lock-high cycles required to declare lock.
- LOCK_TIMEOUT, 65536, cycles in WAIT_LOCK before a timeout.
- MAX_RETRY, 3, relock attempts after a timeout; used only with PLL_AUTO_RETRY_EN.
- SYNC_STAGES, 2, lock synchroniser depth (≥2).

Ports:
- clkin, input, 1: controller clock (PLL reference clock).
- rst_n, input, 1: asynchronous active-low reset.
- cfg_valid, input, 1: new configuration offered.
- cfg_ready, output, 1: controller can accept a configuration.
- cfg_idsel, cfg_fbdsel, cfg_odsel, input, 6 each: requested divider selects (encoded).
- cfg_psda, cfg_dutyda, input, 4 each: requested phase/duty selects.
- pll_lock, input, 1: raw PLL LOCK (asynchronous).
- pll_reset, output, 1: to rPLL RESET.
- pll_reset_p, output, 1: to rPLL RESET_P.
- idsel, fbdsel, odsel, output, 6 each: registered selects to the PLL.
- psda, dutyda, output, 4 each: registered selects to the PLL.
- locked, output, 1: qualified lock; downstream logic is released on this.
- busy, output, 1: reconfiguration or relock in progress.
- err_timeout, output, 1: sticky lock-timeout flag.
- relock_cnt, output, 8: saturating count of lock-loss events.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Select outputs = DEF_* values; pll_reset=1; pll_reset_p=0.
  - locked=0, busy=1, cfg_ready=0, err_timeout=0, relock_cnt=0.
  - State = PLL_RST with the counter cleared.
- pll_lock passes through a SYNC_STAGES flop chain to give lock_s. Only lock_s is used. Synchroniser flops reset to 0.
- States:
  - PLL_RST: pll_reset=1 for exactly RST_CYCLES cycles → WAIT_LOCK. Entry clears the settle and timeout counters.
  - PHASE_RST: pll_reset_p=1 for RST_CYCLES cycles → WAIT_LOCK.
  - WAIT_LOCK: settle counter increments while lock_s=1 and clears when lock_s=0. When it reaches SETTLE_CYCLES → LOCKED. If the timeout counter reaches LOCK_TIMEOUT first → set err_timeout, then retry policy applies (see Optional Feature).
  - LOCKED: locked=1, busy=0, cfg_ready=1. lock_s low for 2 consecutive cycles → relock_cnt+1 (saturates at 255), locked=0 the next cycle, → PLL_RST.
  - ERR: locked=0, busy=0, cfg_ready=1, pll_reset held 1. Left only by an accepted cfg or by reset.
- Handshake:
  - Transfer occurs when cfg_valid & cfg_ready on a rising edge. Cfg fields are sampled on that edge.
  - cfg_ready drops the following cycle.
  - cfg_valid held while cfg_ready=0 is ignored; no queueing.
- Accepted cfg classification:
  - Divider selects differ from the current outputs → all selects updated, → PLL_RST, locked=0 next cycle.
  - Only psda/dutyda differ → phase/duty selects updated, → PHASE_RST, locked=0 next cycle.
  - Identical → no state change, locked stays 1, cfg_ready re-asserts after one cycle.
  - Any accepted cfg clears err_timeout and the retry count.
  - From ERR, every accepted cfg goes to PLL_RST.
- Simultaneous events:
  - Lock loss and cfg accept in the same LOCKED cycle: the cfg wins, so new selects are applied and the full PLL_RST path is taken.
  - A lock-loss count is then also recorded if the 2-cycle loss condition is met.
- Selects are registered and change only on state entry to PLL_RST/PHASE_RST. They are stable during each reset pulse.
- Counters are sized with $clog2 of their limits. Timeout comparisons are ≥, not ==.

Optional Feature:
- PLL_AUTO_RETRY_EN defined: after a WAIT_LOCK timeout, the retry count increments and the FSM returns to PLL_RST with the same selects. After MAX_RETRY failed retries → ERR.
- PLL_AUTO_RETRY_EN undefined: the first timeout goes directly to ERR. MAX_RETRY is unused and no retry counter is built.

Test Plan:
- Release rst_n with pll_lock rising at cycle 40 → pll_reset high cycles 0–15. locked=1 exactly SETTLE_CYCLES+SYNC_STAGES cycles after pll_lock rises. Selects = 63/61/62/4/8.
- Once locked, send cfg with psda 4→9 and other fields unchanged → pll_reset_p pulses 16 cycles, pll_reset stays 0. psda=9, locked re-asserts after settle.
- Once locked, send cfg with fbdsel 61→59 → pll_reset pulses 16 cycles, fbdsel=59, busy=1 until relock.
- Once locked, drop pll_lock for 1 cycle → no effect. Drop it for 3 cycles → relock_cnt=1, full PLL_RST sequence. Repeat 300 times → relock_cnt=255.
- Hold pll_lock=0:
  - With PLL_AUTO_RETRY_EN, MAX_RETRY=3 → 4 PLL_RST pulses, then ERR with err_timeout=1 and cfg_ready=1.
  - Without PLL_AUTO_RETRY_EN → 1 pulse, then ERR.
- In ERR, send an identical cfg → err_timeout clears, PLL_RST entered. Assert rst_n low mid-WAIT_LOCK → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/pll_dyn_ctrl.sv
// pll_dyn_ctrl: runtime divider/phase reconfiguration and lock supervision for the capture rPLL.
// Optional build macro PLL_AUTO_RETRY_EN: retry PLL_RST up to MAX_RETRY times after a lock timeout.
module pll_dyn_ctrl #(
  parameter logic [5:0] DEF_IDSEL     = 6'd63,
  parameter logic [5:0] DEF_FBDSEL    = 6'd61,
  parameter logic [5:0] DEF_ODSEL     = 6'd62,
  parameter logic [3:0] DEF_PSDA      = 4'd4,
  parameter logic [3:0] DEF_DUTYDA    = 4'd8,
  parameter int         RST_CYCLES    = 16,
  parameter int         SETTLE_CYCLES = 1024,
  parameter int         LOCK_TIMEOUT  = 65536,
  parameter int         MAX_RETRY     = 3,
  parameter int         SYNC_STAGES   = 2
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [5:0] cfg_idsel,
  input  logic [5:0] cfg_fbdsel,
  input  logic [5:0] cfg_odsel,
  input  logic [3:0] cfg_psda,
  input  logic [3:0] cfg_dutyda,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       pll_reset_p,
  output logic [5:0] idsel,
  output logic [5:0] fbdsel,
  output logic [5:0] odsel,
  output logic [3:0] psda,
  output logic [3:0] dutyda,
  output logic       locked,
  output logic       busy,
  output logic       err_timeout,
  output logic [7:0] relock_cnt
);

  localparam int RCW = $clog2(RST_CYCLES + 1);
  localparam int SCW = $clog2(SETTLE_CYCLES + 1);
  localparam int TCW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [RCW-1:0] RST_LAST    = RCW'(RST_CYCLES - 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [TCW-1:0] TMO_LAST    = TCW'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    PHASE_RST = 3'd1,
    WAIT_LOCK = 3'd2,
    LOCKED    = 3'd3,
    ERR       = 3'd4
  } state_t;

  state_t               state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [RCW-1:0]       rst_cnt_q;
  logic [SCW-1:0]       settle_q;
  logic [TCW-1:0]       tmo_q;
  logic                 lost_q;
  logic [5:0]           idsel_q, fbdsel_q, odsel_q;
  logic [3:0]           psda_q, dutyda_q;
  logic                 pll_reset_q, pll_reset_p_q;
  logic                 locked_q, busy_q, cfg_ready_q, err_q;
  logic [7:0]           relock_q;

  logic lock_s, cfg_fire, div_chg, ph_chg, loss, settle_hit, tmo_hit, retry_ok;

  // Only the last synchroniser stage is ever observed by the FSM.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign lock_s     = sync_q[SYNC_STAGES-1];
  assign cfg_fire   = cfg_valid & cfg_ready_q;
  assign div_chg    = {cfg_idsel, cfg_fbdsel, cfg_odsel} != {idsel_q, fbdsel_q, odsel_q};
  assign ph_chg     = {cfg_psda, cfg_dutyda} != {psda_q, dutyda_q};
  assign loss       = (state_q == LOCKED) & ~lock_s & lost_q;
  assign settle_hit = lock_s & (settle_q >= SETTLE_LAST);
  assign tmo_hit    = (tmo_q >= TMO_LAST) & ~settle_hit;

`ifdef PLL_AUTO_RETRY_EN
  localparam int RTW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RTW-1:0] RETRY_MAX = RTW'(MAX_RETRY);
  logic [RTW-1:0] retry_q;

  assign retry_ok = (retry_q < RETRY_MAX);

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      retry_q <= '0;
    end else if (cfg_fire) begin
      retry_q <= '0;
    end else if ((state_q == WAIT_LOCK) && tmo_hit && retry_ok) begin
      retry_q <= retry_q + RTW'(1);
    end
  end
`else
  assign retry_ok = 1'b0;
`endif

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= PLL_RST;
      rst_cnt_q     <= '0;
      settle_q      <= '0;
      tmo_q         <= '0;
      lost_q        <= 1'b0;
      idsel_q       <= DEF_IDSEL;
      fbdsel_q      <= DEF_FBDSEL;
      odsel_q       <= DEF_ODSEL;
      psda_q        <= DEF_PSDA;
      dutyda_q      <= DEF_DUTYDA;
      pll_reset_q   <= 1'b1;
      pll_reset_p_q <= 1'b0;
      locked_q      <= 1'b0;
      busy_q        <= 1'b1;
      cfg_ready_q   <= 1'b0;
      err_q         <= 1'b0;
      relock_q      <= 8'd0;
    end else begin
      case (state_q)
        PLL_RST, PHASE_RST: begin
          settle_q <= '0;
          tmo_q    <= '0;
          if (rst_cnt_q >= RST_LAST) begin
            rst_cnt_q     <= '0;
            state_q       <= WAIT_LOCK;
            pll_reset_q   <= 1'b0;
            pll_reset_p_q <= 1'b0;
          end else begin
            rst_cnt_q <= rst_cnt_q + RCW'(1);
          end
        end

        WAIT_LOCK: begin
          lost_q   <= 1'b0;
          tmo_q    <= tmo_q + TCW'(1);
          settle_q <= lock_s ? settle_q + SCW'(1) : '0;
          if (settle_hit) begin
            state_q     <= LOCKED;
            locked_q    <= 1'b1;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
          end else if (tmo_hit) begin
            err_q       <= 1'b1;
            pll_reset_q <= 1'b1;
            if (retry_ok) begin
              state_q <= PLL_RST;
            end else begin
              state_q     <= ERR;
              busy_q      <= 1'b0;
              cfg_ready_q <= 1'b1;
            end
          end
        end

        LOCKED: begin
          lost_q <= ~lock_s;
          if (loss && (relock_q != 8'hFF)) begin
            relock_q <= relock_q + 8'd1;
          end
          if (cfg_fire) begin
            err_q <= 1'b0;
          end
          // A lock loss forces the full reset path even when the cfg only touches phase/duty.
          if (loss || (cfg_fire && div_chg)) begin
            if (cfg_fire) begin
              idsel_q  <= cfg_idsel;
              fbdsel_q <= cfg_fbdsel;
              odsel_q  <= cfg_odsel;
              psda_q   <= cfg_psda;
              dutyda_q <= cfg_dutyda;
            end
            state_q     <= PLL_RST;
            pll_reset_q <= 1'b1;
            locked_q    <= 1'b0;
            busy_q      <= 1'b1;
            cfg_ready_q <= 1'b0;
          end else if (cfg_fire && ph_chg) begin
            psda_q        <= cfg_psda;
            dutyda_q      <= cfg_dutyda;
            state_q       <= PHASE_RST;
            pll_reset_p_q <= 1'b1;
            locked_q      <= 1'b0;
            busy_q        <= 1'b1;
            cfg_ready_q   <= 1'b0;
          end else begin
            cfg_ready_q <= ~cfg_fire;
          end
        end

        ERR: begin
          if (cfg_fire) begin
            idsel_q     <= cfg_idsel;
            fbdsel_q    <= cfg_fbdsel;
            odsel_q     <= cfg_odsel;
            psda_q      <= cfg_psda;
            dutyda_q    <= cfg_dutyda;
            err_q       <= 1'b0;
            state_q     <= PLL_RST;
            busy_q      <= 1'b1;
            cfg_ready_q <= 1'b0;
          end
        end

        default: begin
          state_q     <= PLL_RST;
          rst_cnt_q   <= '0;
          pll_reset_q <= 1'b1;
          locked_q    <= 1'b0;
          busy_q      <= 1'b1;
          cfg_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign pll_reset   = pll_reset_q;
  assign pll_reset_p = pll_reset_p_q;
  assign idsel       = idsel_q;
  assign fbdsel      = fbdsel_q;
  assign odsel       = odsel_q;
  assign psda        = psda_q;
  assign dutyda      = dutyda_q;
  assign locked      = locked_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;
  assign relock_cnt  = relock_q;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Bench for pll_dyn_ctrl: directed scenarios with a cycle model checked at every falling edge.
// Shortened settle/timeout limits keep the 300-relock scenario short.
module tb_pll_dyn_ctrl;

  localparam int RST_C    = 16;
  localparam int SETTLE_C = 8;
  localparam int TMO_C    = 64;
  localparam int SYNC_C   = 2;
  localparam int MAXR     = 3;
`ifdef PLL_AUTO_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif

  localparam int MP_RST  = 0;
  localparam int MP_PH   = 1;
  localparam int MP_WAIT = 2;
  localparam int MP_LOCK = 3;
  localparam int MP_ERR  = 4;

  logic clkin = 1'b0;
  always #5 clkin = ~clkin;

  logic       rst_n, cfg_valid, pll_lock;
  logic [5:0] cfg_idsel, cfg_fbdsel, cfg_odsel;
  logic [3:0] cfg_psda, cfg_dutyda;
  logic       cfg_ready, pll_reset, pll_reset_p, locked, busy, err_timeout;
  logic [5:0] idsel, fbdsel, odsel;
  logic [3:0] psda, dutyda;
  logic [7:0] relock_cnt;

  pll_dyn_ctrl #(
    .RST_CYCLES(RST_C), .SETTLE_CYCLES(SETTLE_C), .LOCK_TIMEOUT(TMO_C),
    .MAX_RETRY(MAXR), .SYNC_STAGES(SYNC_C)
  ) dut (
    .clkin(clkin), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idsel(cfg_idsel), .cfg_fbdsel(cfg_fbdsel), .cfg_odsel(cfg_odsel),
    .cfg_psda(cfg_psda), .cfg_dutyda(cfg_dutyda), .pll_lock(pll_lock),
    .pll_reset(pll_reset), .pll_reset_p(pll_reset_p),
    .idsel(idsel), .fbdsel(fbdsel), .odsel(odsel), .psda(psda), .dutyda(dutyda),
    .locked(locked), .busy(busy), .err_timeout(err_timeout), .relock_cnt(relock_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Model: mode, pulse cycles left, lock-high run, wait length, lock-low run, retries.
  int m_mode, m_left, m_run, m_waited, m_low, m_retry;
  logic [SYNC_C-1:0] m_pipe;
  logic [5:0] e_id, e_fb, e_od;
  logic [3:0] e_ps, e_du;
  logic e_rst, e_rstp, e_lk, e_busy, e_rdy, e_err;
  logic [7:0] e_rc;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = MP_RST; m_left = RST_C; m_run = 0; m_waited = 0; m_low = 0; m_retry = 0;
    m_pipe = '0;
    e_id = 6'd63; e_fb = 6'd61; e_od = 6'd62; e_ps = 4'd4; e_du = 4'd8;
    e_rst = 1'b1; e_rstp = 1'b0; e_lk = 1'b0; e_busy = 1'b1; e_rdy = 1'b0; e_err = 1'b0;
    e_rc = 8'd0;
  endtask

  task automatic start_pulse(input bit phase_only);
    m_mode = phase_only ? MP_PH : MP_RST;
    m_left = RST_C;
    e_rst  = !phase_only;
    e_rstp = phase_only;
    e_lk = 1'b0; e_busy = 1'b1; e_rdy = 1'b0;
  endtask

  task automatic load_all();
    e_id = cfg_idsel; e_fb = cfg_fbdsel; e_od = cfg_odsel; e_ps = cfg_psda; e_du = cfg_dutyda;
  endtask

  task automatic model_step();
    logic ls, acc, dchg, pchg, lost;
    ls = m_pipe[SYNC_C-1];
    m_pipe = {m_pipe[SYNC_C-2:0], pll_lock};
    acc  = cfg_valid && e_rdy;
    dchg = ({cfg_idsel, cfg_fbdsel, cfg_odsel} != {e_id, e_fb, e_od});
    pchg = ({cfg_psda, cfg_dutyda} != {e_ps, e_du});
    case (m_mode)
      MP_RST, MP_PH: begin
        m_left--;
        if (m_left == 0) begin
          m_mode = MP_WAIT; m_run = 0; m_waited = 0; e_rst = 1'b0; e_rstp = 1'b0;
        end
      end
      MP_WAIT: begin
        m_waited++;
        m_run = ls ? m_run + 1 : 0;
        if (m_run >= SETTLE_C) begin
          m_mode = MP_LOCK; m_low = 0; e_lk = 1'b1; e_busy = 1'b0; e_rdy = 1'b1;
        end else if (m_waited >= TMO_C) begin
          e_err = 1'b1;
          if (RETRY_ON && m_retry < MAXR) begin
            m_retry++;
            start_pulse(1'b0);
          end else begin
            m_mode = MP_ERR; e_rst = 1'b1; e_busy = 1'b0; e_rdy = 1'b1; e_lk = 1'b0;
          end
        end
      end
      MP_LOCK: begin
        m_low = ls ? 0 : m_low + 1;
        lost = (m_low >= 2);
        if (lost && e_rc != 8'd255) e_rc = e_rc + 8'd1;
        if (acc) begin e_err = 1'b0; m_retry = 0; end
        if (lost || (acc && dchg)) begin
          if (acc) load_all();
          start_pulse(1'b0);
        end else if (acc && pchg) begin
          e_ps = cfg_psda; e_du = cfg_dutyda;
          start_pulse(1'b1);
        end else begin
          e_rdy = !acc;
        end
      end
      MP_ERR: begin
        if (acc) begin
          e_err = 1'b0; m_retry = 0;
          load_all();
          start_pulse(1'b0);
        end
      end
      default: model_reset();
    endcase
  endtask

  task automatic compare_all();
    check("idsel", int'(idsel), int'(e_id));
    check("fbdsel", int'(fbdsel), int'(e_fb));
    check("odsel", int'(odsel), int'(e_od));
    check("psda", int'(psda), int'(e_ps));
    check("dutyda", int'(dutyda), int'(e_du));
    check("pll_reset", int'(pll_reset), int'(e_rst));
    check("pll_reset_p", int'(pll_reset_p), int'(e_rstp));
    check("locked", int'(locked), int'(e_lk));
    check("busy", int'(busy), int'(e_busy));
    check("cfg_ready", int'(cfg_ready), int'(e_rdy));
    check("err_timeout", int'(err_timeout), int'(e_err));
    check("relock_cnt", int'(relock_cnt), int'(e_rc));
  endtask

  task automatic cyc();
    @(posedge clkin);
    if (rst_n) model_step(); else model_reset();
    @(negedge clkin);
    compare_all();
  endtask

  task automatic send_cfg(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                          input logic [3:0] p, input logic [3:0] d);
    cfg_idsel = a; cfg_fbdsel = b; cfg_odsel = c; cfg_psda = p; cfg_dutyda = d;
    cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
  endtask

  // Counts over the current sample plus n-1 further cycles.
  task automatic observe(input int n, output int rst_hi, output int rstp_hi, output int rst_falls);
    logic prev;
    rst_hi = int'(pll_reset); rstp_hi = int'(pll_reset_p); rst_falls = 0;
    prev = pll_reset;
    for (int i = 1; i < n; i++) begin
      cyc();
      rst_hi += int'(pll_reset);
      rstp_hi += int'(pll_reset_p);
      if (prev && !pll_reset) rst_falls++;
      prev = pll_reset;
    end
  endtask

  initial begin
    int hi, hip, falls, first;
    rst_n = 1'b0; cfg_valid = 1'b0; pll_lock = 1'b0;
    cfg_idsel = 6'd63; cfg_fbdsel = 6'd61; cfg_odsel = 6'd62; cfg_psda = 4'd4; cfg_dutyda = 4'd8;
    model_reset();
    repeat (3) cyc();
    check("rst_pll_reset", int'(pll_reset), 1);
    check("rst_busy", int'(busy), 1);
    check("rst_cfg_ready", int'(cfg_ready), 0);

    // Power-up: lock arrives 40 cycles after reset release.
    rst_n = 1'b1;
    hi = int'(pll_reset); first = -1;
    for (int k = 0; k < 80; k++) begin
      if (k == 40) pll_lock = 1'b1;
      cyc();
      hi += int'(pll_reset);
      if (locked && first < 0) first = k;
    end
    check("powerup_reset_len", hi, 16);
    check("powerup_lock_latency", first - 40 + 1, SETTLE_C + SYNC_C);
    check("powerup_idsel", int'(idsel), 63);
    check("powerup_fbdsel", int'(fbdsel), 61);
    check("powerup_odsel", int'(odsel), 62);
    check("powerup_psda", int'(psda), 4);
    check("powerup_dutyda", int'(dutyda), 8);

    // Phase-only change.
    send_cfg(6'd63, 6'd61, 6'd62, 4'd9, 4'd8);
    check("ph_ready_drop", int'(cfg_ready), 0);
    observe(40, hi, hip, falls);
    check("ph_resetp_len", hip, 16);
    check("ph_reset_len", hi, 0);
    check("ph_psda", int'(psda), 9);
    check("ph_relocked", int'(locked), 1);

    // Divider change.
    send_cfg(6'd63, 6'd59, 6'd62, 4'd9, 4'd8);
    check("div_busy", int'(busy), 1);
    check("div_fbdsel", int'(fbdsel), 59);
    observe(40, hi, hip, falls);
    check("div_reset_len", hi, 16);
    check("div_resetp_len", hip, 0);
    check("div_relocked", int'(locked), 1);

    // Identical cfg.
    send_cfg(6'd63, 6'd59, 6'd62, 4'd9, 4'd8);
    check("same_ready_drop", int'(cfg_ready), 0);
    check("same_locked", int'(locked), 1);
    cyc();
    check("same_ready_back", int'(cfg_ready), 1);

    // One-cycle lock glitch is filtered.
    pll_lock = 1'b0; cyc(); pll_lock = 1'b1;
    observe(10, hi, hip, falls);
    check("glitch_reset", hi, 0);
    check("glitch_relock_cnt", int'(relock_cnt), 0);

    // Three-cycle loss triggers a full relock.
    pll_lock = 1'b0; repeat (3) cyc(); pll_lock = 1'b1;
    observe(40, hi, hip, falls);
    check("loss_reset_len", hi, 16);
    check("loss_relock_cnt", int'(relock_cnt), 1);
    check("loss_relocked", int'(locked), 1);
    for (int r = 0; r < 299; r++) begin
      pll_lock = 1'b0; repeat (3) cyc(); pll_lock = 1'b1;
      repeat (37) cyc();
    end
    check("relock_saturate", int'(relock_cnt), 255);

    // Permanent lock loss ends in ERR.
    pll_lock = 1'b0;
    observe(400, hi, hip, falls);
    check("tmo_pulses", falls, RETRY_ON ? MAXR + 1 : 1);
    check("tmo_err", int'(err_timeout), 1);
    check("tmo_ready", int'(cfg_ready), 1);
    check("tmo_pll_reset", int'(pll_reset), 1);
    check("tmo_busy", int'(busy), 0);

    // Identical cfg leaves ERR.
    send_cfg(6'd63, 6'd59, 6'd62, 4'd9, 4'd8);
    check("err_clear", int'(err_timeout), 0);
    check("err_busy", int'(busy), 1);
    repeat (25) cyc();

    // Asynchronous reset in the middle of WAIT_LOCK.
    @(posedge clkin);
    model_step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_pll_reset", int'(pll_reset), 1);
    check("async_locked", int'(locked), 0);
    check("async_busy", int'(busy), 1);
    check("async_fbdsel", int'(fbdsel), 61);
    check("async_psda", int'(psda), 4);
    check("async_relock_cnt", int'(relock_cnt), 0);
    @(negedge clkin);
    compare_all();
    cyc();
    rst_n = 1'b1; pll_lock = 1'b1;
    observe(40, hi, hip, falls);
    check("post_reset_locked", int'(locked), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
